// File: rtl/fifo_word_packer.sv
// fifo_word_packer: read-side consumer of the dual-clock byte FIFO.
// Pops bytes under a credit rule, absorbs the FIFO read latency in a small
// skid buffer and packs LANES bytes into one word behind a valid/ready port.
// A flush pulse emits a zero-padded partial word.
// Optional macro FIFO_PACK_MSB_FIRST_EN: first byte lands in the top lane.
`timescale 1ns/1ps
module fifo_word_packer #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     fifo_rinc,
  input  logic                     fifo_rempty,
  input  logic [WIDTH-1:0]         fifo_rdata,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*LANES-1:0]   out_data,
  output logic [$clog2(LANES):0]   out_count
);

  localparam int SKID_DEPTH = RD_LAT + 1;
  localparam int PW         = $clog2(SKID_DEPTH);
  localparam int CNTW       = $clog2(SKID_DEPTH + 1);
  localparam int LCW        = $clog2(LANES) + 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(SKID_DEPTH - 1);
  localparam logic [CNTW:0]   CREDIT   = (CNTW+1)'(SKID_DEPTH);

  typedef enum logic [1:0] {FILL = 2'd0, FULL = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  skid_mem [SKID_DEPTH];
  logic [PW-1:0]     skid_wr_ptr_reg, skid_rd_ptr_reg;
  logic [CNTW-1:0]   skid_cnt_reg, skid_cnt_next;
  logic [RD_LAT-1:0] vld_sr_reg, vld_sr_next;
  logic [CNTW-1:0]   inflight;
  logic [WIDTH-1:0]  lane_reg [LANES];
  logic [WIDTH-1:0]  lane_next [LANES];
  logic [LCW-1:0]    lane_cnt_reg, lane_cnt_next;
  logic [LCW-1:0]    out_count_reg, out_count_next;
  logic              flush_pend_reg, flush_pend_next;
  logic              drain_word_reg, drain_word_next;
  logic              flush_clr;
  logic              skid_wr, skid_rd;
  logic [WIDTH-1:0]  skid_rd_data;

  // Number of pops still travelling through the FIFO read pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNTW'(vld_sr_reg[i]);
    end
  end

  // Pop only when the skid buffer is guaranteed room for everything in flight.
  assign fifo_rinc = ~fifo_rempty & ~flush_pend_reg &
                     (({1'b0, inflight} + {1'b0, skid_cnt_reg}) < CREDIT);

  assign skid_wr      = vld_sr_reg[RD_LAT-1];
  assign skid_rd_data = skid_mem[skid_rd_ptr_reg];
  assign out_valid    = (state_reg == FULL);
  assign out_count    = out_count_reg;

  // Lane-to-word mapping; lanes are cleared after every accepted word, so
  // unfilled lanes of a flushed word read as zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef FIFO_PACK_MSB_FIRST_EN
    assign out_data[WIDTH*(LANES-gi)-1 -: WIDTH] = lane_reg[gi];
`else
    assign out_data[WIDTH*gi +: WIDTH] = lane_reg[gi];
`endif
  end

  // Packer FSM next-state, lane updates and skid read decision.
  always_comb begin
    state_next      = state_reg;
    lane_next       = lane_reg;
    lane_cnt_next   = lane_cnt_reg;
    out_count_next  = out_count_reg;
    drain_word_next = drain_word_reg;
    flush_clr       = 1'b0;
    skid_rd         = 1'b0;
    case (state_reg)
      FILL: begin
        if (skid_cnt_reg != '0) begin
          skid_rd = 1'b1;
          for (int i = 0; i < LANES; i++) begin
            if (lane_cnt_reg == LCW'(i)) lane_next[i] = skid_rd_data;
          end
          lane_cnt_next = lane_cnt_reg + LCW'(1);
          if (lane_cnt_reg == LCW'(LANES - 1)) begin
            state_next      = FULL;
            out_count_next  = LCW'(LANES);
            drain_word_next = 1'b0;
          end
        end else if (flush_pend_reg && (inflight == '0)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (lane_cnt_reg != '0) begin
          out_count_next  = lane_cnt_reg;
          drain_word_next = 1'b1;
          state_next      = FULL;
        end else begin
          flush_clr  = 1'b1;
          state_next = FILL;
        end
      end
      FULL: begin
        if (out_ready) begin
          for (int i = 0; i < LANES; i++) lane_next[i] = '0;
          lane_cnt_next   = '0;
          out_count_next  = '0;
          drain_word_next = 1'b0;
          flush_clr       = drain_word_reg;
          state_next      = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Flush request latch, skid occupancy and pop-tracking shift register.
  always_comb begin
    flush_pend_next = flush_pend_reg;
    if (flush_clr)  flush_pend_next = 1'b0;
    else if (flush) flush_pend_next = 1'b1;
    skid_cnt_next  = skid_cnt_reg + CNTW'(skid_wr) - CNTW'(skid_rd);
    vld_sr_next    = vld_sr_reg << 1;
    vld_sr_next[0] = fifo_rinc;
  end

  // Skid storage; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (skid_wr) skid_mem[skid_wr_ptr_reg] <= fifo_rdata;
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= FILL;
      skid_wr_ptr_reg <= '0;
      skid_rd_ptr_reg <= '0;
      skid_cnt_reg    <= '0;
      vld_sr_reg      <= '0;
      lane_cnt_reg    <= '0;
      out_count_reg   <= '0;
      flush_pend_reg  <= 1'b0;
      drain_word_reg  <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else begin
      state_reg      <= state_next;
      skid_cnt_reg   <= skid_cnt_next;
      vld_sr_reg     <= vld_sr_next;
      lane_cnt_reg   <= lane_cnt_next;
      out_count_reg  <= out_count_next;
      flush_pend_reg <= flush_pend_next;
      drain_word_reg <= drain_word_next;
      lane_reg       <= lane_next;
      if (skid_wr)
        skid_wr_ptr_reg <= (skid_wr_ptr_reg == LAST_IDX) ? '0 : skid_wr_ptr_reg + PW'(1);
      if (skid_rd)
        skid_rd_ptr_reg <= (skid_rd_ptr_reg == LAST_IDX) ? '0 : skid_rd_ptr_reg + PW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed and randomized checks of fifo_word_packer
// against a queue-based byte-stream model with a latency-modelled FIFO.
`timescale 1ns/1ps
module tb_fifo_word_packer;

  localparam int TB_W  = 8;
  localparam int TB_L  = 4;
  localparam int TB_RL = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  fifo_rinc;
  logic                  fifo_rempty;
  logic [TB_W-1:0]       fifo_rdata;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [TB_W*TB_L-1:0]  out_data;
  logic [$clog2(TB_L):0] out_count;

  int checks = 0;
  int errors = 0;

  // FIFO behavioural model
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pop_cnt = 0;
  logic [7:0] pipe [TB_RL];
  int         gate_mode = 0;   // 0 none, 1 toggle, 2 random
  int         rdy_mode = 0;    // 0 forced, 1 random
  logic       rdy_force = 1'b0;
  logic       tog = 1'b0;
  logic       rnd_gate = 1'b0;
  logic       rnd_rdy = 1'b0;

  logic [7:0]  exp_q [$];
  logic [31:0] obs_data_q [$];
  logic [2:0]  obs_cnt_q [$];

  always #5 clk = ~clk;

  fifo_word_packer #(.WIDTH(TB_W), .LANES(TB_L), .RD_LAT(TB_RL)) dut (
    .clk(clk), .rst(rst), .fifo_rinc(fifo_rinc), .fifo_rempty(fifo_rempty),
    .fifo_rdata(fifo_rdata), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  assign fifo_rempty = (rd_ptr == wr_ptr) ||
                       ((gate_mode == 1) ? tog : (gate_mode == 2) ? rnd_gate : 1'b0);
  assign out_ready   = (rdy_mode == 1) ? rnd_rdy : rdy_force;
  assign fifo_rdata  = pipe[TB_RL-1];

  always @(posedge clk) begin
    for (int i = 1; i < TB_RL; i++) pipe[i] <= pipe[i-1];
    if (fifo_rinc) begin
      pipe[0] <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end else begin
      pipe[0] <= 8'h00;
    end
  end

  always @(negedge clk) begin
    tog      <= ~tog;
    rnd_gate <= ($urandom_range(0, 2) == 0);
    rnd_rdy  <= ($urandom_range(0, 3) != 0);
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_data_q.push_back(out_data);
      obs_cnt_q.push_back(out_count);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (obs_data_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check({tag, "_arrive"}, 64'(obs_data_q.size() >= n), 64'd1);
  endtask

  // Reference: take n bytes from the expected stream, pack them by lane order.
  task automatic get_word(input string tag, input int n);
    logic [31:0] exp_data;
    logic [7:0]  b;
    exp_data = '0;
    for (int i = 0; i < n; i++) begin
      b = exp_q.pop_front();
`ifdef FIFO_PACK_MSB_FIRST_EN
      exp_data[8*(TB_L-1-i) +: 8] = b;
`else
      exp_data[8*i +: 8] = b;
`endif
    end
    check({tag, "_present"}, 64'(obs_data_q.size() != 0), 64'd1);
    if (obs_data_q.size() != 0) begin
      check({tag, "_data"}, 64'(obs_data_q.pop_front()), 64'(exp_data));
      check({tag, "_count"}, 64'(obs_cnt_q.pop_front()), 64'(n));
    end
  endtask

  initial begin
    int p0;
    int b;
    logic [31:0] first;

    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < TB_RL; i++) pipe[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_rinc", 64'(fifo_rinc), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data", 64'(out_data), 64'd0);
    check("reset_count", 64'(out_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Stream of eight bytes with downstream always ready
    rdy_force = 1'b1;
    p0 = pop_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words("stream", 2, 200);
    get_word("stream_w0", 4);
    get_word("stream_w1", 4);
    repeat (5) @(negedge clk);
    check("stream_pops", 64'(pop_cnt - p0), 64'd8);

    // Backpressure: word must hold, pops must stop, nothing lost on release
    rdy_force = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 12; i++) push(8'(8'h20 + i));
    b = 100;
    while (!out_valid && b > 0) begin @(negedge clk); b--; end
    check("bp_valid", 64'(out_valid), 64'd1);
    first = out_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_data", 64'(out_data), 64'(first));
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    check("bp_pop_limit", 64'((pop_cnt - p0) <= TB_L + TB_RL + 1), 64'd1);
    check("bp_rinc_stop", 64'(fifo_rinc), 64'd0);
    rdy_force = 1'b1;
    wait_words("bp", 3, 300);
    get_word("bp_w0", 4);
    get_word("bp_w1", 4);
    get_word("bp_w2", 4);

    // Flush of a partial word
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (10) @(negedge clk);
    check("flush3_none_yet", 64'(obs_data_q.size()), 64'd0);
    pulse_flush();
    wait_words("flush3", 1, 100);
    get_word("flush3_w", 3);

    // Flush coincident with the second of two pops
    rdy_force = 1'b0;
    p0 = pop_cnt;
    push(8'h11); push(8'h22);
    @(negedge clk);
    pulse_flush();
    push(8'h33);
    b = 100;
    while (!out_valid && b > 0) begin @(negedge clk); b--; end
    check("fl_inflight_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fl_inflight_no_pop", 64'(fifo_rinc), 64'd0);
    end
    check("fl_inflight_pops", 64'(pop_cnt - p0), 64'd2);
    rdy_force = 1'b1;
    wait_words("fl_inflight", 1, 50);
    get_word("fl_inflight_w", 2);
    repeat (10) @(negedge clk);
    pulse_flush();
    wait_words("fl_tail", 1, 100);
    get_word("fl_tail_w", 1);

    // Flush with nothing buffered produces no word
    repeat (5) @(negedge clk);
    pulse_flush();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("empty_flush_valid", 64'(out_valid), 64'd0);
    end

    // Sparse FIFO: empty flag toggling every cycle
    gate_mode = 1;
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    wait_words("sparse", 2, 400);
    get_word("sparse_w0", 4);
    get_word("sparse_w1", 4);
    gate_mode = 0;

    // Randomized stream with random gaps and random backpressure
    gate_mode = 2;
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) push(8'($urandom_range(0, 255)));
    wait_words("rand", 10, 3000);
    for (int i = 0; i < 10; i++) get_word("rand_w", 4);
    gate_mode = 0;
    rdy_mode = 0;
    rdy_force = 1'b1;

    // Reset in the middle of a word
    repeat (5) @(negedge clk);
    push(8'h61); push(8'h62); push(8'h63);
    repeat (5) @(negedge clk);
    check("rstmid_none", 64'(obs_data_q.size()), 64'd0);
    rst = 1'b1;
    #1;
    check("rstmid_valid", 64'(out_valid), 64'd0);
    check("rstmid_data", 64'(out_data), 64'd0);
    check("rstmid_count", 64'(out_count), 64'd0);
    check("rstmid_rinc", 64'(fifo_rinc), 64'd0);
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(8'(8'h71 + i));
    wait_words("rstmid", 1, 100);
    get_word("rstmid_w", 4);

    repeat (10) @(negedge clk);
    check("no_extra_words", 64'(obs_data_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
